// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver state encoding, pixel width and the
// 100 MHz timing defaults also used by the transmitter.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    IDLE       = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } state_t;

  localparam int PIXEL_BITS   = 24;
  localparam int T0H          = 40;
  localparam int T1H          = 80;
  localparam int T_BIT        = 125;
  localparam int BIT_THRESH   = 60;
  localparam int MIN_HIGH     = 15;
  localparam int LATCH_CYCLES = 5000;

endpackage

// File: rtl/ws2812b_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus registered rise/fall
// strobes; strobes appear 3 clk after the raw edge, o_level after 2 clk.
module ws2812b_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B NRZ receiver: pulse-width bit decoder, 24-bit GRB word assembly and
// latch-gap framing. Define WS2812B_RX_FORWARD_EN to forward words 1..N on dout.
module ws2812b_rx #(
  parameter int BIT_THRESH   = ws2812b_pkg::BIT_THRESH,
  parameter int MIN_HIGH     = ws2812b_pkg::MIN_HIGH,
  parameter int LATCH_CYCLES = ws2812b_pkg::LATCH_CYCLES,
  parameter int MAX_PIXELS   = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          din,
  output logic [23:0]                   pixel_data,
  output logic                          pixel_valid,
  output logic [$clog2(MAX_PIXELS)-1:0] pixel_index,
  output logic                          frame_end,
  output logic                          bit_error,
  output logic                          dout
);
  import ws2812b_pkg::state_t;
  import ws2812b_pkg::WAIT_LATCH;
  import ws2812b_pkg::IDLE;
  import ws2812b_pkg::HIGH;
  import ws2812b_pkg::LOW;
  import ws2812b_pkg::PIXEL_BITS;

  localparam int CW = $clog2(LATCH_CYCLES + 1);
  localparam int IW = $clog2(MAX_PIXELS);
  localparam logic [CW-1:0] C_THRESH   = CW'(BIT_THRESH);
  localparam logic [CW-1:0] C_MIN      = CW'(MIN_HIGH);
  localparam logic [CW-1:0] C_LATCH_M1 = CW'(LATCH_CYCLES - 1);
  localparam logic [4:0]    C_LAST_BIT = 5'(PIXEL_BITS - 1);

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_bit;
  logic [PIXEL_BITS-1:0] w_shift_next;

  state_t                r_state;
  logic [CW-1:0]         r_hcnt;
  logic [CW-1:0]         r_lcnt;
  logic [4:0]            r_bit_cnt;
  logic [PIXEL_BITS-1:0] r_shift;
  logic [PIXEL_BITS-1:0] r_pixel_data;
  logic                  r_pixel_valid;
  logic [IW-1:0]         r_pixel_index;
  logic                  r_frame_end;
  logic                  r_bit_error;

  ws2812b_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (din),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_bit        = (r_hcnt >= C_THRESH);
  assign w_shift_next = {r_shift[PIXEL_BITS-2:0], w_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= WAIT_LATCH;
      r_hcnt        <= '0;
      r_lcnt        <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_pixel_index <= '0;
      r_frame_end   <= 1'b0;
      r_bit_error   <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_end   <= 1'b0;
      r_bit_error   <= 1'b0;
      // The index names the word during its strobe and advances right after.
      if (r_pixel_valid) r_pixel_index <= r_pixel_index + IW'(1);

      unique case (r_state)
        WAIT_LATCH: begin
          if (w_level) begin
            r_lcnt <= '0;
          end else if (r_lcnt >= C_LATCH_M1) begin
            r_lcnt  <= '0;
            r_state <= IDLE;
          end else begin
            r_lcnt <= r_lcnt + CW'(1);
          end
        end
        IDLE: begin
          if (w_rise) begin
            r_hcnt  <= CW'(1);
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_fall) begin
            if (r_hcnt < C_MIN) begin
              r_bit_error <= 1'b1;
              r_shift     <= '0;
              r_bit_cnt   <= '0;
              r_lcnt      <= '0;
              r_state     <= WAIT_LATCH;
            end else begin
              r_shift <= w_shift_next;
              r_lcnt  <= '0;
              r_state <= LOW;
              if (r_bit_cnt == C_LAST_BIT) begin
                r_bit_cnt     <= '0;
                r_pixel_data  <= w_shift_next;
                r_pixel_valid <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end else if (r_hcnt < C_THRESH) begin
            r_hcnt <= r_hcnt + CW'(1);
          end
        end
        LOW: begin
          if (w_rise) begin
            r_hcnt  <= CW'(1);
            r_state <= HIGH;
          end else if (r_lcnt >= C_LATCH_M1) begin
            r_frame_end   <= 1'b1;
            r_pixel_index <= '0;
            r_lcnt        <= '0;
            r_state       <= IDLE;
            // A latch gap inside a word means the word was truncated.
            if (r_bit_cnt != 5'd0) begin
              r_bit_error <= 1'b1;
              r_bit_cnt   <= '0;
              r_shift     <= '0;
            end
          end else begin
            r_lcnt <= r_lcnt + CW'(1);
          end
        end
        default: r_state <= WAIT_LATCH;
      endcase
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign pixel_index = r_pixel_index;
  assign frame_end   = r_frame_end;
  assign bit_error   = r_bit_error;

`ifdef WS2812B_RX_FORWARD_EN
  // Word 0 belongs to this node; everything after it is passed downstream.
  logic r_fwd;

  always_ff @(posedge clk) begin
    if (reset || r_frame_end || r_bit_error) begin
      r_fwd <= 1'b0;
    end else if (r_pixel_valid && (r_pixel_index == '0)) begin
      r_fwd <= 1'b1;
    end
  end

  assign dout = w_level & r_fwd;
`else
  assign dout = 1'b0;
`endif

endmodule
